// File: rtl/player_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : player_move_ctrl
// Brief    : Player position controller. Looks up the target tile of a
//            one-step move request, then commits the move or rejects it.
// Revision : 1.0 - initial release
// ============================================================================
module player_move_ctrl #(
    parameter int MAP_W   = 20,
    parameter int MAP_H   = 10,
    parameter int START_X = 1,
    parameter int START_Y = 1,
    parameter int STEP_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              move_req,
    input  logic [1:0]        move_dir,
    input  logic [2:0]        tile_in,
    output logic [5:0]        query_x,
    output logic [5:0]        query_y,
    output logic [5:0]        player_x,
    output logic [5:0]        player_y,
    output logic [STEP_W-1:0] step_count,
    output logic              busy,
    output logic              blocked,
    output logic              stairs_hit
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOOKUP = 2'd1;
    localparam logic [1:0] c_CHECK  = 2'd2;

    localparam logic [5:0]        c_START_X = 6'(START_X);
    localparam logic [5:0]        c_START_Y = 6'(START_Y);
    localparam logic signed [6:0] c_MAP_W   = 7'(MAP_W);
    localparam logic signed [6:0] c_MAP_H   = 7'(MAP_H);
    localparam logic [STEP_W-1:0] c_STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [5:0]        r_px, r_py, r_qx, r_qy, r_tx, r_ty;
    logic [STEP_W-1:0] r_steps;
    logic              r_busy, r_blocked, r_stairs;

    logic signed [6:0] w_dx, w_dy, w_tx, w_ty;
    logic              w_oob, w_wall, w_stairs;

    // Target is formed signed so a step off the left/top edge shows up as negative.
    always_comb begin
        w_dx = 7'sd0;
        w_dy = 7'sd0;
        case (move_dir)
            2'd0:    w_dy = -7'sd1;
            2'd1:    w_dy = 7'sd1;
            2'd2:    w_dx = -7'sd1;
            default: w_dx = 7'sd1;
        endcase
        w_tx = $signed({1'b0, r_px}) + w_dx;
        w_ty = $signed({1'b0, r_py}) + w_dy;
    end

    assign w_oob    = (w_tx < 7'sd0) || (w_tx >= c_MAP_W) ||
                      (w_ty < 7'sd0) || (w_ty >= c_MAP_H);
    assign w_wall   = tile_in[2] || (tile_in == 3'b010);
    assign w_stairs = (tile_in == 3'b011);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_state   <= c_IDLE;
            r_px      <= c_START_X;
            r_py      <= c_START_Y;
            r_qx      <= c_START_X;
            r_qy      <= c_START_Y;
            r_tx      <= c_START_X;
            r_ty      <= c_START_Y;
            r_steps   <= '0;
            r_busy    <= 1'b0;
            r_blocked <= 1'b0;
            r_stairs  <= 1'b0;
        end else begin
            r_blocked <= 1'b0;
            r_stairs  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_qx <= r_px;
                    r_qy <= r_py;
                    if (move_req) begin
                        if (w_oob) begin
                            r_blocked <= 1'b1;
                        end else begin
                            r_qx    <= w_tx[5:0];
                            r_qy    <= w_ty[5:0];
                            r_tx    <= w_tx[5:0];
                            r_ty    <= w_ty[5:0];
                            r_busy  <= 1'b1;
                            r_state <= c_LOOKUP;
                        end
                    end
                end
                // Wait cycle so a registered map read has its data ready.
                c_LOOKUP: r_state <= c_CHECK;
                c_CHECK: begin
                    if (w_wall) begin
                        r_blocked <= 1'b1;
                        r_qx      <= r_px;
                        r_qy      <= r_py;
                    end else begin
                        r_px     <= r_tx;
                        r_py     <= r_ty;
                        r_qx     <= r_tx;
                        r_qy     <= r_ty;
                        r_stairs <= w_stairs;
                        if (r_steps != '1)
                            r_steps <= r_steps + c_STEP_ONE;
                    end
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign query_x    = r_qx;
    assign query_y    = r_qy;
    assign player_x   = r_px;
    assign player_y   = r_py;
    assign step_count = r_steps;
    assign busy       = r_busy;
    assign blocked    = r_blocked;
    assign stairs_hit = r_stairs;

endmodule
`default_nettype wire

// File: tb/tb_player_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_move_ctrl
// Brief    : Self-checking bench for player_move_ctrl over four start points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_move_ctrl;

    typedef struct {
        logic [1:0] dir;
        int         ex;
        int         ey;
        int         esteps;
        bit         eblk;
        bit         estairs;
    } vec_t;

    typedef struct {
        int ex;
        int ey;
        int esteps;
        bit eblk;
        bit estairs;
    } exp_t;

    logic clk;
    logic rst;
    logic       restart  [4];
    logic       move_req [4];
    logic [1:0] move_dir [4];
    logic [2:0] tile     [4];
    logic [5:0] qx [4], qy [4], px [4], py [4];
    logic [9:0] steps [4];
    logic       busy [4], blocked [4], stairs [4];

    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic prev_busy;

    // Map: (1,0) wall, (2,1) road1, (1,2) code 1xx, (0,1) and (14,2) stairs.
    function automatic logic [2:0] map_tile(input logic [5:0] x, input logic [5:0] y);
        if (x == 6'd1 && y == 6'd0)  return 3'b010;
        if (x == 6'd2 && y == 6'd1)  return 3'b001;
        if (x == 6'd1 && y == 6'd2)  return 3'b101;
        if (x == 6'd0 && y == 6'd1)  return 3'b011;
        if (x == 6'd14 && y == 6'd2) return 3'b011;
        return 3'b000;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_dut
        localparam int LX = (i == 0) ? 1 : (i == 1) ? 0 : (i == 2) ? 13 : 19;
        localparam int LY = (i == 0) ? 1 : (i == 1) ? 1 : (i == 2) ? 2 : 9;
        localparam int LW = (i == 1) ? 2 : 10;
        logic [LW-1:0] sc;
        assign tile[i]  = map_tile(qx[i], qy[i]);
        assign steps[i] = 10'(sc);
        player_move_ctrl #(
            .MAP_W(20), .MAP_H(10), .START_X(LX), .START_Y(LY), .STEP_W(LW)
        ) u_dut (
            .clk(clk), .rst(rst), .restart(restart[i]),
            .move_req(move_req[i]), .move_dir(move_dir[i]), .tile_in(tile[i]),
            .query_x(qx[i]), .query_y(qy[i]), .player_x(px[i]), .player_y(py[i]),
            .step_count(sc), .busy(busy[i]), .blocked(blocked[i]),
            .stairs_hit(stairs[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input int i, input logic [1:0] dir);
        move_req[i] = 1'b1;
        move_dir[i] = dir;
        tick();
        move_req[i] = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_sb(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d results outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Scoreboard for instance 0: each blocked pulse or busy falling edge is one result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (blocked[0] || stairs[0] || (prev_busy && !busy[0]))) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got blocked=%0d stairs=%0d busy_fall=%0d, required no event",
                         blocked[0], stairs[0], prev_busy && !busy[0]);
            end else begin
                e = sb_q.pop_front();
                check("sb_px", int'(px[0]), e.ex);
                check("sb_py", int'(py[0]), e.ey);
                check("sb_steps", int'(steps[0]), e.esteps);
                check("sb_blocked", int'(blocked[0]), int'(e.eblk));
                check("sb_stairs", int'(stairs[0]), int'(e.estairs));
            end
        end
        prev_busy = busy[0];
    end

    initial begin
        vec_t vecs[8];
        checks    = 0;
        errors    = 0;
        prev_busy = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            restart[i]  = 1'b0;
            move_req[i] = 1'b0;
            move_dir[i] = 2'd0;
        end
        vecs[0] = '{2'd2, 1, 1, 2, 1'b0, 1'b0};
        vecs[1] = '{2'd0, 1, 1, 2, 1'b1, 1'b0};
        vecs[2] = '{2'd1, 1, 1, 2, 1'b1, 1'b0};
        vecs[3] = '{2'd2, 0, 1, 3, 1'b0, 1'b1};
        vecs[4] = '{2'd2, 0, 1, 3, 1'b1, 1'b0};
        vecs[5] = '{2'd0, 0, 0, 4, 1'b0, 1'b0};
        vecs[6] = '{2'd0, 0, 0, 4, 1'b1, 1'b0};
        vecs[7] = '{2'd3, 0, 0, 4, 1'b1, 1'b0};

        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("rst_px", int'(px[0]), 1);
        check("rst_py", int'(py[0]), 1);
        check("rst_qx", int'(qx[0]), 1);
        check("rst_qy", int'(qy[0]), 1);
        check("rst_steps", int'(steps[0]), 0);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_pulses", int'({blocked[0], stairs[0]}), 0);
        check("rst_qx_b", int'(qx[1]), 0);

        // First move with cycle-exact latency.
        move_req[0] = 1'b1;
        move_dir[0] = 2'd3;
        sb_q.push_back('{2, 1, 1, 1'b0, 1'b0});
        tick();
        move_req[0] = 1'b0;
        check("lat_q_n1", int'({qx[0], qy[0]}), int'({6'd2, 6'd1}));
        check("lat_busy_n1", int'(busy[0]), 1);
        check("lat_px_n1", int'(px[0]), 1);
        tick();
        check("lat_busy_n2", int'(busy[0]), 1);
        check("lat_px_n2", int'(px[0]), 1);
        tick();
        check("lat_px_n3", int'(px[0]), 2);
        check("lat_steps_n3", int'(steps[0]), 1);
        check("lat_busy_n3", int'(busy[0]), 0);
        wait_sb("first_move");

        for (int v = 0; v < 8; v++) begin
            move_req[0] = 1'b1;
            move_dir[0] = vecs[v].dir;
            sb_q.push_back('{vecs[v].ex, vecs[v].ey, vecs[v].esteps, vecs[v].eblk, vecs[v].estairs});
            tick();
            move_req[0] = 1'b0;
            wait_sb("vec");
            tick();
        end
        check("tbl_qx", int'(qx[0]), 0);
        check("tbl_qy", int'(qy[0]), 0);

        // Left edge: rejected immediately, no lookup.
        move_req[1] = 1'b1;
        move_dir[1] = 2'd2;
        tick();
        move_req[1] = 1'b0;
        check("edge_blocked_n1", int'(blocked[1]), 1);
        check("edge_busy_n1", int'(busy[1]), 0);
        check("edge_q_n1", int'({qx[1], qy[1]}), int'({6'd0, 6'd1}));
        tick();
        check("edge_blocked_n2", int'(blocked[1]), 0);
        check("edge_busy_n2", int'(busy[1]), 0);

        // Right and bottom edges.
        move_req[3] = 1'b1;
        move_dir[3] = 2'd3;
        tick();
        check("right_blocked", int'(blocked[3]), 1);
        move_dir[3] = 2'd1;
        tick();
        move_req[3] = 1'b0;
        check("bottom_blocked", int'(blocked[3]), 1);
        check("corner_busy", int'(busy[3]), 0);
        tick();
        check("corner_q", int'({qx[3], qy[3]}), int'({6'd19, 6'd9}));

        // Stairs plus a request while busy.
        move_req[2] = 1'b1;
        move_dir[2] = 2'd3;
        tick();
        move_dir[2] = 2'd2;
        check("stairs_busy_n1", int'(busy[2]), 1);
        tick();
        move_req[2] = 1'b0;
        tick();
        check("stairs_px", int'(px[2]), 14);
        check("stairs_py", int'(py[2]), 2);
        check("stairs_pulse", int'(stairs[2]), 1);
        check("stairs_noblk", int'(blocked[2]), 0);
        check("stairs_steps", int'(steps[2]), 1);
        tick();
        check("stairs_pulse_end", int'(stairs[2]), 0);
        repeat (4) tick();
        check("dropped_px", int'(px[2]), 14);
        check("dropped_steps", int'(steps[2]), 1);
        check("dropped_busy", int'(busy[2]), 0);

        // Saturation with a 2-bit counter.
        for (int k = 0; k < 5; k++) move(1, 2'd3);
        check("sat_px", int'(px[1]), 5);
        check("sat_steps", int'(steps[1]), 3);

        // Restart during LOOKUP aborts the move.
        move_req[0] = 1'b1;
        move_dir[0] = 2'd1;
        tick();
        move_req[0] = 1'b0;
        check("rs_busy_lookup", int'(busy[0]), 1);
        restart[0] = 1'b1;
        sb_q.push_back('{1, 1, 0, 1'b0, 1'b0});
        tick();
        restart[0] = 1'b0;
        check("rs_px", int'(px[0]), 1);
        check("rs_py", int'(py[0]), 1);
        check("rs_steps", int'(steps[0]), 0);
        check("rs_busy", int'(busy[0]), 0);
        check("rs_q", int'({qx[0], qy[0]}), int'({6'd1, 6'd1}));
        repeat (4) tick();
        check("rs_px_later", int'(px[0]), 1);
        wait_sb("restart");

        // Restart together with move_req drops the move.
        restart[0]  = 1'b1;
        move_req[0] = 1'b1;
        move_dir[0] = 2'd3;
        tick();
        restart[0]  = 1'b0;
        move_req[0] = 1'b0;
        check("rsmv_busy", int'(busy[0]), 0);
        repeat (3) tick();
        check("rsmv_px", int'(px[0]), 1);
        check("rsmv_steps", int'(steps[0]), 0);
        wait_sb("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
